// File: rtl/i2c_cmd_arbiter_if.sv
// Requester and controller-side signals of the I2C command arbiter.
// slave = the arbiter, master = the surrounding requesters/controller.
interface i2c_cmd_arbiter_if #(
    parameter int N_REQ = 2
);
    logic [N_REQ-1:0]    iREQ;
    logic [24*N_REQ-1:0] iREQ_DATA;
    logic [N_REQ-1:0]    oDONE;
    logic [N_REQ-1:0]    oERR;
    logic                oBUSY;
    logic                oCTRL_CLK;
    logic [23:0]         oI2C_DATA;
    logic                oI2C_GO;
    logic                iI2C_END;
    logic                iI2C_ACK;

    modport slave (
        input  iREQ, iREQ_DATA, iI2C_END, iI2C_ACK,
        output oDONE, oERR, oBUSY, oCTRL_CLK,
        output oI2C_DATA, oI2C_GO
    );

    modport master (
        output iREQ, iREQ_DATA, iI2C_END, iI2C_ACK,
        input  oDONE, oERR, oBUSY, oCTRL_CLK,
        input  oI2C_DATA, oI2C_GO
    );
endinterface

// File: rtl/i2c_cmd_arbiter.sv
// Round-robin arbiter sharing one I2C controller between N_REQ requesters.
// Retries on NACK/timeout and generates the controller work clock.
module i2c_cmd_arbiter #(
    parameter int N_REQ         = 2,
    parameter int CLK_DIV       = 2500,
    parameter int MAX_RETRY     = 3,
    parameter int TIMEOUT_TICKS = 255,
    parameter int GAP_TICKS     = 2
) (
    input logic              iCLK,
    input logic              iRST_N,
    i2c_cmd_arbiter_if.slave bus
);
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int DW = $clog2(CLK_DIV + 2);
    localparam int RW = $clog2(MAX_RETRY + 2);
    localparam int TW = $clog2(TIMEOUT_TICKS + 2);
    localparam int GW = $clog2(GAP_TICKS + 2);
    localparam int TL = (TIMEOUT_TICKS > 0) ? TIMEOUT_TICKS - 1 : 0;
    localparam int GL = (GAP_TICKS > 0) ? GAP_TICKS - 1 : 0;

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_WAIT, S_GAP, S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   div_q, div_d;
    logic            cclk_q, cclk_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [23:0]     word_q, word_d;
    logic [23:0]     data_q, data_d;
    logic [RW-1:0]   retry_q, retry_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic            armed_q, armed_d;
    logic            pend_q, pend_d;
    logic            fail_q, fail_d;
    logic            go_q, go_d;
    logic [N_REQ-1:0] done_q, done_d;
    logic [N_REQ-1:0] err_q, err_d;

    logic            wrap, tick;
    logic            gnt_vld;
    logic [IW-1:0]   gnt_idx;
    logic [23:0]     words [N_REQ];
    logic [N_REQ-1:0] oh;
    logic            end_ok, tmo_hit, fin, gap_last;

    function automatic logic [IW-1:0] nxt(
        input logic [IW-1:0] p,
        input int            k
    );
        int s;
        s = (int'(p) + k) % N_REQ;
        return IW'(s);
    endfunction

    always_comb begin
        wrap   = (div_q == DW'(CLK_DIV));
        div_d  = wrap ? '0 : div_q + 1'b1;
        cclk_d = cclk_q ^ wrap;
        tick   = wrap & ~cclk_q;
    end

    always_comb begin
        for (int k = 0; k < N_REQ; k++) begin
            words[k] = bus.iREQ_DATA[24*k +: 24];
        end
    end

    // Descending scan so the candidate closest after ptr_q wins.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            if (bus.iREQ[nxt(ptr_q, k)]) begin
                gnt_vld = 1'b1;
                gnt_idx = nxt(ptr_q, k);
            end
        end
    end

    assign oh       = N_REQ'(1) << idx_q;
    assign end_ok   = armed_q & bus.iI2C_END;
    assign tmo_hit  = (tmo_q == TW'(TL));
    assign fin      = end_ok | tmo_hit;
    assign gap_last = (gap_q == GW'(GL));

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            cclk_q  <= 1'b0;
            idx_q   <= '0;
            ptr_q   <= IW'(N_REQ - 1);
            word_q  <= '0;
            data_q  <= '0;
            retry_q <= '0;
            tmo_q   <= '0;
            gap_q   <= '0;
            armed_q <= 1'b0;
            pend_q  <= 1'b0;
            fail_q  <= 1'b0;
            go_q    <= 1'b0;
            done_q  <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            cclk_q  <= cclk_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            word_q  <= word_d;
            data_q  <= data_d;
            retry_q <= retry_d;
            tmo_q   <= tmo_d;
            gap_q   <= gap_d;
            armed_q <= armed_d;
            pend_q  <= pend_d;
            fail_q  <= fail_d;
            go_q    <= go_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (tick) begin
            unique case (state_q)
                S_IDLE:  if (gnt_vld) state_d = S_ISSUE;
                S_ISSUE: state_d = S_WAIT;
                S_WAIT:  if (fin) state_d = S_GAP;
                S_GAP:   if (gap_last) state_d = pend_q ? S_ISSUE : S_DONE;
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        word_d  = word_q;
        data_d  = data_q;
        retry_d = retry_q;
        tmo_d   = tmo_q;
        gap_d   = gap_q;
        armed_d = armed_q;
        pend_d  = pend_q;
        fail_d  = fail_q;
        go_d    = go_q;
        done_d  = '0;
        err_d   = '0;
        if (tick) begin
            unique case (state_q)
                S_IDLE: if (gnt_vld) begin
                    idx_d   = gnt_idx;
                    word_d  = words[gnt_idx];
                    retry_d = '0;
                end
                S_ISSUE: begin
                    data_d  = word_q;
                    go_d    = 1'b1;
                    tmo_d   = '0;
                    armed_d = 1'b0;
                end
                S_WAIT: begin
                    if (!bus.iI2C_END) armed_d = 1'b1;
                    if (fin) begin
                        go_d   = 1'b0;
                        gap_d  = '0;
                        pend_d = 1'b0;
                        fail_d = 1'b0;
                        // A timeout is handled exactly like a NACK.
                        if (!(end_ok && !bus.iI2C_ACK)) begin
                            if (retry_q < RW'(MAX_RETRY)) begin
                                retry_d = retry_q + 1'b1;
                                pend_d  = 1'b1;
                            end else begin
                                fail_d = 1'b1;
                            end
                        end
                    end else begin
                        tmo_d = tmo_q + 1'b1;
                    end
                end
                S_GAP: if (!gap_last) gap_d = gap_q + 1'b1;
                S_DONE: begin
                    done_d = oh;
                    err_d  = fail_q ? oh : '0;
                    ptr_d  = idx_q;
                end
                default: ;
            endcase
        end
    end

    assign bus.oDONE     = done_q;
    assign bus.oERR      = err_q;
    assign bus.oBUSY     = (state_q != S_IDLE);
    assign bus.oCTRL_CLK = cclk_q;
    assign bus.oI2C_DATA = data_q;
    assign bus.oI2C_GO   = go_q;
endmodule

// File: tb/tb_i2c_cmd_arbiter.sv
// Bench for i2c_cmd_arbiter: controller BFM, vector table and scoreboard,
// plus hand sequences for stale END and mid-transfer reset.
module tb_i2c_cmd_arbiter;
    localparam int N    = 2;
    localparam int DIV  = 3;
    localparam int MR   = 3;
    localparam int TMO  = 20;
    localparam int GAP  = 2;
    localparam int TCYC = 2 * (DIV + 1);

    typedef struct {
        int          idx;
        logic [23:0] data;
        int          mode;
        logic        err;
        int          gos;
        int          gcyc;
    } vec_t;

    typedef struct {
        int          idx;
        logic [23:0] data;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    i2c_cmd_arbiter_if #(.N_REQ(N)) bus();

    i2c_cmd_arbiter #(
        .N_REQ(N), .CLK_DIV(DIV), .MAX_RETRY(MR),
        .TIMEOUT_TICKS(TMO), .GAP_TICKS(GAP)
    ) dut (
        .iCLK(clk),
        .iRST_N(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // mode: 0 ack, 1 nack, 2 END never returns, 3 manual
    int   mode = 0;
    logic man_end = 1'b1;
    logic man_ack = 1'b0;
    logic bfm_end, bfm_ack, bfm_busy;
    int   bfm_cnt;

    always @(posedge bus.oCTRL_CLK or negedge rst_n) begin
        if (!rst_n) begin
            bfm_end  <= 1'b1;
            bfm_ack  <= 1'b0;
            bfm_busy <= 1'b0;
            bfm_cnt  <= 0;
        end else if (!bus.oI2C_GO) begin
            bfm_busy <= 1'b0;
            bfm_end  <= 1'b1;
        end else if (!bfm_busy) begin
            bfm_busy <= 1'b1;
            bfm_end  <= 1'b0;
            bfm_cnt  <= 3;
        end else if (mode != 2 && bfm_cnt > 0) begin
            bfm_cnt <= bfm_cnt - 1;
            if (bfm_cnt == 1) begin
                bfm_end <= 1'b1;
                bfm_ack <= (mode == 1);
            end
        end
    end

    assign bus.iI2C_END = (mode == 3) ? man_end : bfm_end;
    assign bus.iI2C_ACK = (mode == 3) ? man_ack : bfm_ack;

    int          n_chk = 0;
    int          n_fail = 0;
    int          go_rises = 0;
    int          go_cyc = 0;
    logic        go_prev = 1'b0;
    logic [23:0] go_data = '0;
    exp_t        sb[$];
    vec_t        vt[4];

    task automatic check(input string nm,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        if (bus.oI2C_GO && !go_prev) begin
            go_rises++;
            go_data = bus.oI2C_DATA;
        end
        if (bus.oI2C_GO) go_cyc++;
        go_prev = bus.oI2C_GO;
    endtask

    task automatic wait_done(input bit drop);
        int   n;
        exp_t e;
        n = 0;
        do begin
            step();
            n++;
        end while (bus.oDONE == '0 && n < 3000);
        check("done_seen", 32'(|bus.oDONE), 32'd1);
        if (bus.oDONE == '0) return;
        check("sb_nonempty", 32'(sb.size() > 0), 32'd1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        if (drop) bus.iREQ[e.idx] = 1'b0;
        check("done_idx", 32'(bus.oDONE), 32'd1 << e.idx);
        check("err", 32'(bus.oERR), e.err ? (32'd1 << e.idx) : 32'd0);
        check("go_data", 32'(go_data), 32'(e.data));
        check("data_hold", 32'(bus.oI2C_DATA), 32'(e.data));
        step();
        check("done_width", 32'(bus.oDONE), 32'd0);
    endtask

    task automatic wait_go();
        int n;
        n = 0;
        while (!bus.oI2C_GO && n < 200) begin
            step();
            n++;
        end
        check("go_rise", 32'(bus.oI2C_GO), 32'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          r0, c0, n;
        logic [N-1:0] seen;

        vt[0] = '{0, 24'hBA0500, 0, 1'b0, 1, -1};
        vt[1] = '{0, 24'h0F0F0F, 2, 1'b1, MR + 1, (MR + 1) * TMO * TCYC};
        vt[2] = '{1, 24'h123456, 0, 1'b0, 1, -1};
        vt[3] = '{1, 24'hA5C3F0, 1, 1'b1, MR + 1, -1};

        bus.iREQ = '0;
        bus.iREQ_DATA = '0;
        repeat (5) step();
        check("rst_go", 32'(bus.oI2C_GO), 32'd0);
        check("rst_data", 32'(bus.oI2C_DATA), 32'd0);
        check("rst_done", 32'(bus.oDONE), 32'd0);
        check("rst_err", 32'(bus.oERR), 32'd0);
        check("rst_busy", 32'(bus.oBUSY), 32'd0);
        check("rst_cclk", 32'(bus.oCTRL_CLK), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) begin
            mode = vt[i].mode;
            r0 = go_rises;
            c0 = go_cyc;
            bus.iREQ_DATA[24*vt[i].idx +: 24] = vt[i].data;
            bus.iREQ[vt[i].idx] = 1'b1;
            sb.push_back('{vt[i].idx, vt[i].data, vt[i].err});
            wait_done(1'b1);
            check("go_pulses", go_rises - r0, vt[i].gos);
            check("busy_idle", 32'(bus.oBUSY), 32'd0);
            if (vt[i].gcyc >= 0)
                check("tmo_go_cycles", go_cyc - c0, vt[i].gcyc);
        end

        // Both requesters held: pointer sits at 1, so 0,1,0,1.
        mode = 0;
        bus.iREQ_DATA = {24'h222222, 24'h111111};
        for (int i = 0; i < 4; i++)
            sb.push_back('{i % 2, (i % 2) ? 24'h222222 : 24'h111111, 1'b0});
        bus.iREQ = 2'b11;
        for (int i = 0; i < 4; i++) wait_done(i == 3);
        bus.iREQ = '0;

        // Stale END=1 must not complete; only the next high does.
        mode = 3;
        man_end = 1'b1;
        man_ack = 1'b0;
        r0 = go_rises;
        bus.iREQ_DATA[47:24] = 24'h5A5A01;
        bus.iREQ[1] = 1'b1;
        sb.push_back('{1, 24'h5A5A01, 1'b0});
        wait_go();
        bus.iREQ_DATA[47:24] = 24'hFFFFFF;
        repeat (3 * TCYC) step();
        check("stale_hold", 32'(bus.oI2C_GO), 32'd1);
        man_end = 1'b0;
        repeat (2 * TCYC) step();
        check("low_hold", 32'(bus.oI2C_GO), 32'd1);
        man_end = 1'b1;
        n = 0;
        while (bus.oI2C_GO && n < 4 * TCYC) begin
            step();
            n++;
        end
        check("stale_drop", 32'(bus.oI2C_GO), 32'd0);
        check("stale_lat", 32'(n <= TCYC + 1), 32'd1);
        wait_done(1'b1);
        check("stale_pulses", go_rises - r0, 32'd1);

        // Reset mid WAIT_END abandons the transfer silently.
        mode = 2;
        bus.iREQ_DATA[23:0] = 24'hC0FFEE;
        bus.iREQ[0] = 1'b1;
        wait_go();
        repeat (2 * TCYC) step();
        #1 rst_n = 1'b0;
        #1;
        check("arst_go", 32'(bus.oI2C_GO), 32'd0);
        check("arst_cclk", 32'(bus.oCTRL_CLK), 32'd0);
        check("arst_busy", 32'(bus.oBUSY), 32'd0);
        bus.iREQ = '0;
        seen = '0;
        repeat (5) begin
            step();
            seen |= bus.oDONE;
        end
        rst_n = 1'b1;
        repeat (4 * TCYC) begin
            step();
            seen |= bus.oDONE;
        end
        check("no_done_rst", 32'(seen), 32'd0);
        check("idle_after", 32'(bus.oBUSY), 32'd0);

        mode = 0;
        r0 = go_rises;
        bus.iREQ_DATA[23:0] = 24'h010203;
        bus.iREQ[0] = 1'b1;
        sb.push_back('{0, 24'h010203, 1'b0});
        wait_done(1'b1);
        check("fresh_pulses", go_rises - r0, 32'd1);
        check("sb_drained", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
